// File: rtl/drp_pkg.sv
// Shared definitions for the DRP address generator: controller state
// encoding, configuration address map, default dither tables and a
// width helper.
package drp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } drp_state_t;

  // Configuration address map; the write-dither block follows the
  // read-dither block, so its base depends on the dither period m.
  localparam int CFG_ADDR_S  = 0;
  localparam int CFG_ADDR_P  = 1;
  localparam int CFG_ADDR_RD = 2;

  // Default dither tables, entry k in bits [4k+3:4k].
  localparam logic [7:0]  DITHER_M2     = 8'h01;
  localparam logic [15:0] DITHER_M4     = 16'h0321;
  localparam logic [31:0] DITHER_M8     = 32'h41607253;
  localparam logic [63:0] DITHER_M16_RD = 64'hC503BF7AE24D9861;
  localparam logic [63:0] DITHER_M16_WD = 64'h63F2C17BEAD09485;

  // Bit width able to hold v-1, never less than one bit.
  function automatic int clog2_safe(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  function automatic int cfg_addr_wd(input int mm);
    return CFG_ADDR_RD + mm;
  endfunction

  // Default dither entry k for period mm; only m=16 has distinct RD/WD.
  function automatic logic [3:0] dither_default(input int mm, input int k, input logic is_wd);
    logic [3:0] v;
    v = 4'd0;
    case (mm)
      2:       v = DITHER_M2[(k % 2) * 4 +: 4];
      4:       v = DITHER_M4[(k % 4) * 4 +: 4];
      8:       v = DITHER_M8[(k % 8) * 4 +: 4];
      16:      v = is_wd ? DITHER_M16_WD[(k % 16) * 4 +: 4]
                         : DITHER_M16_RD[(k % 16) * 4 +: 4];
      default: v = 4'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/drp_lane.sv
// One lane of the DRP address datapath. Stage 1 applies the read dither
// and forms r*P; stage 2 adds the offset, applies the write dither and
// drops the fan-out bits to give the neuron index.
module drp_lane
  import drp_pkg::*;
#(
  parameter int W      = 5,
  parameter int L      = 2,
  parameter int A      = 4,
  parameter int LOG2FO = 1,
  parameter int M      = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_en,
  input  logic [W-1:0]        i_x,
  input  logic [W-1:0]        i_offset,
  input  logic [W-1:0]        i_stride,
  input  logic [M-1:0][L-1:0] i_rd_tab,
  input  logic [M-1:0][L-1:0] i_wd_tab,
  output logic [A-1:0]        o_index
);

  logic [W-1:0] w_r;
  logic [W-1:0] w_prod;
  logic [W-1:0] w_rp;
  logic [W-1:0] w_w;
  logic [A-1:0] w_index;
  logic [W-1:0] r_prod;
  logic [A-1:0] r_index;

  // Masking rather than slicing keeps this valid when the address is no
  // wider than the dither field.
  assign w_r     = (i_x & ~W'(M - 1)) | W'(i_rd_tab[i_x[L-1:0]]);
  assign w_prod  = w_r * i_stride;
  assign w_rp    = i_offset + r_prod;
  assign w_w     = (w_rp & ~W'(M - 1)) | W'(i_wd_tab[w_rp[L-1:0]]);
  assign w_index = A'(w_w >> LOG2FO);

  // Stage 1: dithered position times stride.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prod <= '0;
    end else if (i_en) begin
      r_prod <= w_prod;
    end
  end

  // Stage 2: offset, write dither and index extraction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_index <= '0;
    end else if (i_en) begin
      r_index <= w_index;
    end
  end

  assign o_index = r_index;

endmodule

// File: rtl/drp_addr_gen.sv
// DRP address generator: per-cycle neuron addresses for all z lanes of a
// junction pass, through a two-stage pipeline with valid/ready output.
// Build option: DRP_DITHER_PROG_EN makes the RD/WD dither tables
// writable; otherwise they are fixed to the default tables.
//
// state | meaning
// IDLE  | waiting for start; configuration writes accepted
// RUN   | issuing beats 0..N-1 into the pipeline
// DRAIN | all beats issued; waiting for the last one to be accepted
module drp_addr_gen
  import drp_pkg::*;
#(
  parameter  int fo    = 2,
  parameter  int p     = 16,
  parameter  int z     = 8,
  parameter  int DRP_s = 3,
  parameter  int DRP_p = 23,
  parameter  int m     = z / fo,
  localparam int W     = clog2_safe(fo * p),
  localparam int N     = (fo * p) / z,
  localparam int C     = clog2_safe(N),
  localparam int A     = clog2_safe(p),
  localparam int CW    = clog2_safe(2 + 2 * m)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  output logic           busy,
  input  logic           cfg_we,
  input  logic [CW-1:0]  cfg_addr,
  input  logic [W-1:0]   cfg_wdata,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [C-1:0]   out_cycle,
  output logic           out_last,
  output logic [A*z-1:0] memory_index_package,
  output logic           done
);

  localparam int L      = $clog2(m);
  localparam int LOG2Z  = $clog2(z);
  localparam int LOG2FO = $clog2(fo);

  drp_state_t          r_state;
  logic                r_busy;
  logic [C-1:0]        r_cnt;
  logic                r_v1;
  logic [C-1:0]        r_c1;
  logic                r_last1;
  logic                r_out_valid;
  logic [C-1:0]        r_out_cycle;
  logic                r_out_last;
  logic [W-1:0]        r_cfg_s;
  logic [W-1:0]        r_cfg_p;
  logic [m-1:0][L-1:0] w_rd_tab;
  logic [m-1:0][L-1:0] w_wd_tab;
  logic                w_adv;
  logic                w_issue;
  logic                w_hs_last;
  logic                w_cfg_ok;

  // The whole pipeline advances unless a presented beat is being refused.
  assign w_adv     = !r_out_valid || out_ready;
  assign w_issue   = (r_state == RUN) && w_adv;
  assign w_hs_last = r_out_valid && out_ready && r_out_last;
  assign w_cfg_ok  = cfg_we && !r_busy;

  // Controller: beat counter, pass sequencing and pipeline valid tracking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_cnt       <= '0;
      r_v1        <= 1'b0;
      r_c1        <= '0;
      r_last1     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_cycle <= '0;
      r_out_last  <= 1'b0;
    end else begin
      if (w_adv) begin
        r_v1        <= w_issue;
        r_c1        <= r_cnt;
        r_last1     <= w_issue && (r_cnt == C'(N - 1));
        r_out_valid <= r_v1;
        r_out_cycle <= r_c1;
        r_out_last  <= r_last1;
      end
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          if (w_issue) begin
            if (r_cnt == C'(N - 1)) begin
              r_state <= DRAIN;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + C'(1);
            end
          end
        end
        DRAIN: begin
          if (w_hs_last) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Offset and stride; the stride is kept odd so the map stays a permutation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cfg_s <= W'(DRP_s);
      r_cfg_p <= W'(DRP_p) | W'(1);
    end else if (w_cfg_ok) begin
      if (cfg_addr == CW'(CFG_ADDR_S)) r_cfg_s <= cfg_wdata;
      if (cfg_addr == CW'(CFG_ADDR_P)) r_cfg_p <= cfg_wdata | W'(1);
    end
  end

`ifdef DRP_DITHER_PROG_EN
  logic [m-1:0][L-1:0] r_rd_tab;
  logic [m-1:0][L-1:0] r_wd_tab;

  // Programmable dither tables, reloaded with the defaults on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < m; k++) begin
        r_rd_tab[k] <= L'(dither_default(m, k, 1'b0));
        r_wd_tab[k] <= L'(dither_default(m, k, 1'b1));
      end
    end else if (w_cfg_ok) begin
      for (int k = 0; k < m; k++) begin
        if (cfg_addr == CW'(CFG_ADDR_RD + k))    r_rd_tab[k] <= cfg_wdata[L-1:0];
        if (cfg_addr == CW'(cfg_addr_wd(m) + k)) r_wd_tab[k] <= cfg_wdata[L-1:0];
      end
    end
  end

  assign w_rd_tab = r_rd_tab;
  assign w_wd_tab = r_wd_tab;
`else
  for (genvar gk = 0; gk < m; gk++) begin : g_dither
    assign w_rd_tab[gk] = L'(dither_default(m, gk, 1'b0));
    assign w_wd_tab[gk] = L'(dither_default(m, gk, 1'b1));
  end
`endif

  for (genvar gi = 0; gi < z; gi++) begin : g_lane
    logic [W-1:0] w_x;
    assign w_x = (W'(r_cnt) << LOG2Z) | W'(gi);

    drp_lane #(
      .W      (W),
      .L      (L),
      .A      (A),
      .LOG2FO (LOG2FO),
      .M      (m)
    ) u_lane (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_en     (w_adv),
      .i_x      (w_x),
      .i_offset (r_cfg_s),
      .i_stride (r_cfg_p),
      .i_rd_tab (w_rd_tab),
      .i_wd_tab (w_wd_tab),
      .o_index  (memory_index_package[A*gi +: A])
    );
  end

  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign out_cycle = r_out_cycle;
  assign out_last  = r_out_last;
  assign done      = w_hs_last;

endmodule

// File: tb/tb_drp_addr_gen.sv
// Scoreboard bench for drp_addr_gen with the default geometry
// (fo=2, p=16, z=8, m=4, S=3, P=23): expected packages are queued when a
// pass is launched and a negedge monitor pops them on each handshake.
module tb_drp_addr_gen;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        busy;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [4:0]  cfg_wdata;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_cycle;
  logic        out_last;
  logic [31:0] memory_index_package;
  logic        done;

  typedef struct packed {
    logic [1:0]  cyc;
    logic        last;
    logic [31:0] pkg;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] def_pkg [4];
  int          n_checks;
  int          n_fail;
  int          hs_count;
  int          done_count;

  drp_addr_gen dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .start                (start),
    .busy                 (busy),
    .cfg_we               (cfg_we),
    .cfg_addr             (cfg_addr),
    .cfg_wdata            (cfg_wdata),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .out_cycle            (out_cycle),
    .out_last             (out_last),
    .memory_index_package (memory_index_package),
    .done                 (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference index for lane i, cycle c; id selects identity dither tables.
  function automatic logic [3:0] ref_index(input int s, input int pp, input int c, input int i,
                                           input bit id);
    int d [4];
    int x, r, rp, w;
    if (id) begin
      d[0] = 0; d[1] = 1; d[2] = 2; d[3] = 3;
    end else begin
      d[0] = 1; d[1] = 2; d[2] = 3; d[3] = 0;
    end
    x  = c * 8 + i;
    r  = (x & ~3) | d[x & 3];
    rp = (s + r * pp) & 31;
    w  = (rp & ~3) | d[rp & 3];
    return 4'(w >> 1);
  endfunction

  task automatic push_default();
    exp_t e;
    for (int c = 0; c < 4; c++) begin
      e.cyc  = 2'(c);
      e.last = (c == 3);
      e.pkg  = def_pkg[c];
      sb.push_back(e);
    end
  endtask

  task automatic push_model(input int s, input int pp, input bit id);
    exp_t e;
    for (int c = 0; c < 4; c++) begin
      e.cyc  = 2'(c);
      e.last = (c == 3);
      e.pkg  = '0;
      for (int i = 0; i < 8; i++) e.pkg[i*4 +: 4] = ref_index(s, pp, c, i, id);
      sb.push_back(e);
    end
  endtask

  task automatic cfg_write(input int addr, input int data);
    @(posedge clk); #1;
    cfg_we    = 1'b1;
    cfg_addr  = 4'(addr);
    cfg_wdata = 5'(data);
    @(posedge clk); #1;
    cfg_we    = 1'b0;
  endtask

  task automatic wait_not_busy();
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("idle_before_start", busy, 1'b0);
  endtask

  task automatic start_pulse();
    wait_not_busy();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Launch one pass (expectations already queued), drive out_ready from a
  // 4-cycle pattern and record valid/done/busy for the first 8 cycles.
  task automatic run_pass(input logic [3:0] pat, input bit wr_s_busy,
                          output logic [7:0] v_tr, output logic [7:0] d_tr,
                          output logic [7:0] b_tr);
    int  hs0, dn0;
    bit  ok;
    v_tr = '0; d_tr = '0; b_tr = '0;
    ok = 1'b0;
    start_pulse();
    hs0 = hs_count;
    dn0 = done_count;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      out_ready = pat[k % 4];
      if (wr_s_busy && k == 2) begin
        cfg_we = 1'b1; cfg_addr = 4'd0; cfg_wdata = 5'd5;
      end else begin
        cfg_we = 1'b0;
      end
      @(negedge clk);
      if (k < 8) begin
        v_tr[k] = out_valid;
        d_tr[k] = done;
        b_tr[k] = busy;
      end
      if (!busy && sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    cfg_we    = 1'b0;
    out_ready = 1'b1;
    check("pass_complete", ok, 1'b1);
    check("pass_handshakes", hs_count - hs0, 4);
    check("pass_done_pulses", done_count - dn0, 1);
  endtask

  // Monitor: compare every accepted beat against the queue head, and while
  // stalled confirm the presented beat still matches the head.
  always @(negedge clk) begin
    if (reset_n && out_valid) begin
      if (out_ready) begin
        check("beat_expected", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check("beat_pkg", memory_index_package, mon_e.pkg);
          check("beat_cycle", out_cycle, mon_e.cyc);
          check("beat_last", out_last, mon_e.last);
          check("beat_done", done, mon_e.last);
          hs_count++;
        end
      end else if (sb.size() != 0) begin
        check("stall_pkg", memory_index_package, sb[0].pkg);
        check("stall_cycle", out_cycle, sb[0].cyc);
        check("stall_done", done, 1'b0);
      end
    end
    if (done) done_count++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v_tr, d_tr, b_tr;
    bit         found;
    int         dn0;

    n_checks = 0; n_fail = 0; hs_count = 0; done_count = 0;
    reset_n = 1'b0; start = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    out_ready = 1'b1;

    // Hand-computed default pass (S=3, P=23, RD=WD={1,2,3,0}); lane 0 in
    // the low nibble. Beat 0 lanes 0..7 = 13,9,4,0,11,7,2,14.
    def_pkg[0] = 32'hE27B049D;
    def_pkg[1] = 32'hAE37C059;
    def_pkg[2] = 32'h6AF38C15;
    def_pkg[3] = 32'h26BF48D1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_last", out_last, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_cycle", out_cycle, 2'd0);
    check("rst_pkg", memory_index_package, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Default pass with cycle-accurate latency trace.
    push_default();
    run_pass(4'b1111, 1'b0, v_tr, d_tr, b_tr);
    check("trace_valid", v_tr[5:0], 6'b011110);
    check("trace_done", d_tr[5:0], 6'b010000);
    check("trace_busy", b_tr[5:0], 6'b011111);

    // Back-pressure pattern 1,0,0,1.
    push_default();
    run_pass(4'b1001, 1'b0, v_tr, d_tr, b_tr);

    // Even stride is forced odd.
    cfg_write(1, 22);
    check("cfg_p_forced_odd", dut.r_cfg_p, 5'd23);
    push_default();
    run_pass(4'b1111, 1'b0, v_tr, d_tr, b_tr);

    // Offset write while busy is dropped, for this pass and the next.
    push_default();
    run_pass(4'b1111, 1'b1, v_tr, d_tr, b_tr);
    check("cfg_s_unchanged", dut.r_cfg_s, 5'd3);
    push_default();
    run_pass(4'b1111, 1'b0, v_tr, d_tr, b_tr);

`ifdef DRP_DITHER_PROG_EN
    // Identity dither tables with S=0, P=1: index = {c,i} >> 1.
    for (int k = 0; k < 4; k++) begin
      cfg_write(2 + k, k);
      cfg_write(6 + k, k);
    end
    cfg_write(0, 0);
    cfg_write(1, 1);
    push_model(0, 1, 1'b1);
    run_pass(4'b1111, 1'b0, v_tr, d_tr, b_tr);
    check("ident_lane5_c3", ref_index(0, 1, 3, 5, 1'b1), 4'd14);
    push_model(0, 1, 1'b1);
`else
    // Dither writes are ignored in the fixed-table build.
    cfg_write(2, 3);
    cfg_write(6, 3);
    push_default();
    run_pass(4'b1111, 1'b0, v_tr, d_tr, b_tr);
    cfg_write(0, 0);
    cfg_write(1, 1);
    push_model(0, 1, 1'b0);
    run_pass(4'b1111, 1'b0, v_tr, d_tr, b_tr);
    push_model(0, 1, 1'b0);
`endif

    // Reset during beat 2 of a pass with non-default configuration.
    dn0 = done_count;
    start_pulse();
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid && out_cycle == 2'd2) begin
        found = 1'b1;
        break;
      end
    end
    check("midpass_beat2_seen", found, 1'b1);
    #1 reset_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_valid", out_valid, 1'b0);
    check("midrst_last", out_last, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_cycle", out_cycle, 2'd0);
    check("midrst_pkg", memory_index_package, 32'd0);
    check("midrst_no_done", done_count - dn0, 0);
    sb.delete();
    @(posedge clk);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Configuration reverted: the default sequence comes back.
    push_default();
    run_pass(4'b1111, 1'b0, v_tr, d_tr, b_tr);
    check("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
